// File: rtl/vga_stream_pkg.sv
// Shared definitions for the VGA stream sink: frame defaults, FSM encoding, pixel repack.
package vga_stream_pkg;

  localparam int DEF_H_PIXELS = 640;
  localparam int DEF_V_PIXELS = 480;
  localparam int FRAME_PIXELS = DEF_H_PIXELS * DEF_V_PIXELS;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DROP = 2'd2
  } sink_state_t;

  // Keep the top eight bits of each 10-bit channel; truncation, no rounding.
  function automatic logic [23:0] rgb30_to_rgb24(input logic [29:0] px);
    return {px[29:22], px[19:12], px[9:2]};
  endfunction

endpackage

// File: rtl/vga_sink_wr_stage.sv
// Output register for the sink: write request, address/data and the frame status pulses.
// Owns the ready term so back-pressure follows the held write directly.
module vga_sink_wr_stage #(
  parameter int ADDR_W = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [23:0]       data,
  input  logic              done,
  input  logic              err,
  input  logic              wr_wait,
  output logic              ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [23:0]       wr_data,
  output logic              frame_done,
  output logic              frame_error
);

  assign ready = !rst && (!wr_en || !wr_wait);

  // Load on an accepted beat; otherwise hold a stalled write or retire a completed one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en       <= 1'b0;
      wr_addr     <= {ADDR_W{1'b0}};
      wr_data     <= 24'd0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      frame_done  <= load & done;
      frame_error <= load & err;
      if (load) begin
        wr_en <= wr;
        if (wr) begin
          wr_addr <= addr;
          wr_data <= data;
        end else begin
          wr_addr <= wr_addr;
          wr_data <= wr_data;
        end
      end else if (!wr_wait) begin
        wr_en <= 1'b0;
      end else begin
        wr_en <= wr_en;
      end
    end
  end

endmodule

// File: rtl/vga_stream_sink.sv
// Avalon-ST sink for 30-bit RGB frames: framing check, 24-bit repack, linear-address writes.
// Optional err_count output when VGA_SINK_ERRCNT_EN is defined.
module vga_stream_sink
  import vga_stream_pkg::*;
#(
  parameter int H_PIXELS = DEF_H_PIXELS,
  parameter int V_PIXELS = DEF_V_PIXELS,
  parameter int ADDR_W   = 19
) (
  input  logic              clock_vga,
  input  logic              reset,
  input  logic [29:0]       avalon_streaming_sink_data,
  input  logic              avalon_streaming_sink_startofpacket,
  input  logic              avalon_streaming_sink_endofpacket,
  input  logic              avalon_streaming_sink_valid,
  output logic              avalon_streaming_sink_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [23:0]       wr_data,
  output logic              wr_en,
  input  logic              wr_wait,
  output logic [9:0]        col,
  output logic [9:0]        row,
  output logic              frame_done,
  output logic              frame_error
`ifdef VGA_SINK_ERRCNT_EN
  ,
  output logic [15:0]       err_count
`endif
);

  localparam int                FRAME    = H_PIXELS * V_PIXELS;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME - 1);
  localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);
  localparam logic [9:0]        LAST_COL = 10'(H_PIXELS - 1);

  sink_state_t       state_r, state_n;
  logic [ADDR_W-1:0] cnt_r, cnt_n, idx_s;
  logic [9:0]        col_r, row_r, col_n, row_n, base_col_s, base_row_s;
  logic              accept_s, in_frame_s, wr_s, done_s, err_s;
  logic              sop, eop;

  assign sop      = avalon_streaming_sink_startofpacket;
  assign eop      = avalon_streaming_sink_endofpacket;
  assign accept_s = avalon_streaming_sink_valid & avalon_streaming_sink_ready;
  assign col      = col_r;
  assign row      = row_r;

  // SOP always restarts at index 0 (an SOP+EOP beat is an SOP whose EOP then closes the frame).
  always_comb begin
    idx_s      = sop ? {ADDR_W{1'b0}} : cnt_r;
    base_col_s = sop ? 10'd0 : col_r;
    base_row_s = sop ? 10'd0 : row_r;
    in_frame_s = sop | (state_r == ST_RECV);
    wr_s       = 1'b0;
    done_s     = 1'b0;
    err_s      = 1'b0;
    state_n    = state_r;
    cnt_n      = cnt_r;
    col_n      = col_r;
    row_n      = row_r;
    if (in_frame_s) begin
      wr_s  = 1'b1;
      err_s = sop & (state_r == ST_RECV);
      if (eop || (idx_s == LAST_IDX)) begin
        cnt_n = {ADDR_W{1'b0}};
        col_n = 10'd0;
        row_n = 10'd0;
        if (eop) begin
          state_n = ST_IDLE;
          if ((idx_s == LAST_IDX) && !err_s) begin
            done_s = 1'b1;
          end else begin
            err_s = 1'b1;
          end
        end else begin
          state_n = ST_DROP;
          err_s   = 1'b1;
        end
      end else begin
        state_n = ST_RECV;
        cnt_n   = idx_s + ONE;
        if (base_col_s == LAST_COL) begin
          col_n = 10'd0;
          row_n = base_row_s + 10'd1;
        end else begin
          col_n = base_col_s + 10'd1;
          row_n = base_row_s;
        end
      end
    end else if ((state_r == ST_DROP) && eop) begin
      state_n = ST_IDLE;
    end else begin
      state_n = state_r;
    end
  end

  // FSM and position counters advance only on accepted beats.
  always_ff @(posedge clock_vga or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= {ADDR_W{1'b0}};
      col_r   <= 10'd0;
      row_r   <= 10'd0;
    end else if (accept_s) begin
      case (state_n)
        ST_IDLE, ST_RECV, ST_DROP: state_r <= state_n;
        default:                   state_r <= ST_IDLE;
      endcase
      cnt_r <= cnt_n;
      col_r <= col_n;
      row_r <= row_n;
    end else begin
      state_r <= state_r;
      cnt_r   <= cnt_r;
      col_r   <= col_r;
      row_r   <= row_r;
    end
  end

  vga_sink_wr_stage #(
    .ADDR_W (ADDR_W)
  ) u_wr_stage (
    .clk         (clock_vga),
    .rst         (reset),
    .load        (accept_s),
    .wr          (wr_s),
    .addr        (idx_s),
    .data        (rgb30_to_rgb24(avalon_streaming_sink_data)),
    .done        (done_s),
    .err         (err_s),
    .wr_wait     (wr_wait),
    .ready       (avalon_streaming_sink_ready),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .frame_done  (frame_done),
    .frame_error (frame_error)
  );

`ifdef VGA_SINK_ERRCNT_EN
  // Saturating count of framing errors, updated together with the frame_error pulse.
  always_ff @(posedge clock_vga or posedge reset) begin
    if (reset) begin
      err_count <= 16'd0;
    end else if (accept_s && err_s && (err_count != 16'hFFFF)) begin
      err_count <= err_count + 16'd1;
    end else begin
      err_count <= err_count;
    end
  end
`endif

endmodule

// File: tb/tb_vga_stream_sink.sv
// Self-checking bench for vga_stream_sink (4x2 frame): directed framing cases plus random traffic.
module tb_vga_stream_sink;

  localparam int H = 4;
  localparam int V = 2;
  localparam int FRAME = H * V;
  localparam int AW = 3;
  localparam int M_IDLE = 0, M_RECV = 1, M_DROP = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [29:0]   data = 30'd0;
  logic          sop = 1'b0, eop = 1'b0, valid = 1'b0, wr_wait = 1'b0;
  logic          ready, wr_en, frame_done, frame_error;
  logic [AW-1:0] wr_addr;
  logic [23:0]   wr_data;
  logic [9:0]    col, row;
`ifdef VGA_SINK_ERRCNT_EN
  logic [15:0]   err_count;
`endif

  vga_stream_sink #(.H_PIXELS(H), .V_PIXELS(V), .ADDR_W(AW)) dut (
    .clock_vga                           (clk),
    .reset                               (reset),
    .avalon_streaming_sink_data          (data),
    .avalon_streaming_sink_startofpacket (sop),
    .avalon_streaming_sink_endofpacket   (eop),
    .avalon_streaming_sink_valid         (valid),
    .avalon_streaming_sink_ready         (ready),
    .wr_addr                             (wr_addr),
    .wr_data                             (wr_data),
    .wr_en                               (wr_en),
    .wr_wait                             (wr_wait),
    .col                                 (col),
    .row                                 (row),
    .frame_done                          (frame_done),
    .frame_error                         (frame_error)
`ifdef VGA_SINK_ERRCNT_EN
    ,
    .err_count                           (err_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: frame mode, next expected index, and the pending write it implies.
  int   mode, nxt, e_addr, e_data;
  logic e_wr_en, e_done, e_err, acc;

  int          commits[$];
  logic [23:0] commit_data[$];
  int          done_cnt, err_cnt, ready_low;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int repack(input logic [29:0] d);
    int r, g, b;
    r = int'(d) / (1 << 20);
    g = (int'(d) / (1 << 10)) % 1024;
    b = int'(d) % 1024;
    return ((r / 4) * 65536) + ((g / 4) * 256) + (b / 4);
  endfunction

  task automatic model_reset();
    mode = M_IDLE; nxt = 0; e_addr = 0; e_data = 0;
    e_wr_en = 1'b0; e_done = 1'b0; e_err = 1'b0;
  endtask

  task automatic clear_log();
    commits.delete(); commit_data.delete();
    done_cnt = 0; err_cnt = 0; ready_low = 0;
  endtask

  task automatic compare();
    chk("ready", ready, !(e_wr_en && wr_wait));
    chk("wr_en", wr_en, e_wr_en);
    if (e_wr_en) begin
      chk("wr_addr", wr_addr, e_addr);
      chk("wr_data", wr_data, e_data);
    end
    chk("frame_done", frame_done, e_done);
    chk("frame_error", frame_error, e_err);
    chk("col", col, nxt % H);
    chk("row", row, nxt / H);
  endtask

  task automatic model_step();
    int idx;
    acc = valid && !(e_wr_en && wr_wait);
    e_done = 1'b0;
    e_err = 1'b0;
    if (!acc) begin
      if (e_wr_en && !wr_wait) e_wr_en = 1'b0;
    end else begin
      e_wr_en = 1'b0;
      if (sop || mode == M_RECV) begin
        idx = sop ? 0 : nxt;
        e_err = sop && (mode == M_RECV);
        e_wr_en = 1'b1;
        e_addr = idx;
        e_data = repack(data);
        if (eop) begin
          if (idx == FRAME - 1 && !e_err) e_done = 1'b1;
          else e_err = 1'b1;
          mode = M_IDLE; nxt = 0;
        end else if (idx == FRAME - 1) begin
          e_err = 1'b1; mode = M_DROP; nxt = 0;
        end else begin
          nxt = idx + 1; mode = M_RECV;
        end
      end else if (mode == M_DROP && eop) begin
        mode = M_IDLE;
      end
    end
  endtask

  task automatic cycle(input logic v, input logic s, input logic e, input logic w, input logic [29:0] d);
    @(negedge clk);
    valid = v; sop = s; eop = e; wr_wait = w; data = d;
    #1;
    compare();
    if (frame_done) done_cnt++;
    if (frame_error) err_cnt++;
    if (v && !ready) ready_low++;
    if (wr_en && !wr_wait) begin
      commits.push_back(int'(wr_addr));
      commit_data.push_back(wr_data);
    end
    model_step();
  endtask

  task automatic send_frame(input int n, input int eop_at, input logic [29:0] first);
    for (int i = 0; i < n; i++)
      cycle(1'b1, i == 0, i == eop_at, 1'b0, (i == 0) ? first : 30'($urandom));
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 30'd0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 30'd0);
  endtask

  task automatic chk_in_order(input string name);
    for (int i = 0; i < commits.size(); i++) chk(name, commits[i], i);
  endtask

  initial begin
    logic [29:0] px;
    px = {10'h3FF, 10'h003, 10'h155};
    model_reset();
    clear_log();

    #2;
    chk("rst_ready", ready, 1'b0);
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 24'h0);
    chk("rst_col_row", {col, row}, 20'd0);
    chk("rst_pulses", {frame_done, frame_error}, 2'b00);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Clean frame with a known pixel on beat 0.
    clear_log();
    send_frame(8, 7, px);
    chk("clean_writes", commits.size(), 8);
    chk_in_order("clean_addr");
    chk("clean_done", done_cnt, 1);
    chk("clean_err", err_cnt, 0);
    chk("clean_ready_low", ready_low, 0);
    chk("repack_data", commit_data.size() > 0 ? commit_data[0] : 24'hx, 24'hFF0055);

    // Short frame then a clean one restarting at address 0.
    clear_log();
    send_frame(6, 5, 30'($urandom));
    chk("short_writes", commits.size(), 6);
    chk("short_err", err_cnt, 1);
    chk("short_done", done_cnt, 0);
    clear_log();
    send_frame(8, 7, 30'($urandom));
    chk("after_short_writes", commits.size(), 8);
    chk_in_order("after_short_addr");
    chk("after_short_done", done_cnt, 1);

    // Long frame: 10 beats, beats 8 and 9 dropped, then back to idle.
    clear_log();
    send_frame(10, 9, 30'($urandom));
    chk("long_writes", commits.size(), 8);
    chk_in_order("long_addr");
    chk("long_err", err_cnt, 1);
    chk("long_done", done_cnt, 0);
    clear_log();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 30'($urandom));
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 30'd0);
    chk("idle_drop_writes", commits.size(), 0);

    // Three-cycle stall on the write of beat 3 while beat 4 waits.
    clear_log();
    for (int i = 0; i < 4; i++) cycle(1'b1, i == 0, 1'b0, 1'b0, 30'($urandom));
    px = 30'($urandom);
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b1, px);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, px);
    for (int i = 5; i < 8; i++) cycle(1'b1, 1'b0, i == 7, 1'b0, 30'($urandom));
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 30'd0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 30'd0);
    chk("stall_ready_low", ready_low, 3);
    chk("stall_writes", commits.size(), 8);
    chk_in_order("stall_addr");
    chk("stall_done", done_cnt, 1);

    // Asynchronous reset while beat 3 is presented.
    clear_log();
    for (int i = 0; i < 3; i++) cycle(1'b1, i == 0, 1'b0, 1'b0, 30'($urandom));
    @(negedge clk);
    valid = 1'b1; sop = 1'b0; eop = 1'b0; wr_wait = 1'b0; data = 30'($urandom);
    #1 reset = 1'b1;
    #1;
    chk("arst_wr_en", wr_en, 1'b0);
    chk("arst_wr_addr", wr_addr, 0);
    chk("arst_wr_data", wr_data, 24'h0);
    chk("arst_col_row", {col, row}, 20'd0);
    chk("arst_ready", ready, 1'b0);
    chk("arst_pulses", {frame_done, frame_error}, 2'b00);
`ifdef VGA_SINK_ERRCNT_EN
    chk("arst_err_count", err_count, 16'd0);
`endif
    model_reset();
    @(negedge clk);
    valid = 1'b0;
    reset = 1'b0;
    clear_log();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, i == 2, 1'b0, 30'($urandom));
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 30'd0);
    chk("post_rst_drop", commits.size(), 0);
    clear_log();
    send_frame(8, 7, 30'($urandom));
    chk("post_rst_writes", commits.size(), 8);
    chk_in_order("post_rst_addr");
    chk("post_rst_done", done_cnt, 1);

    // Random traffic against the model.
    clear_log();
    for (int i = 0; i < 600; i++)
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 3) == 0, 30'($urandom));
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 30'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
